// File: rtl/wb_sram_burst_bridge_if.sv
// Wishbone B3 bus bundle between a tile/NoC master and wb_sram_burst_bridge.
interface wb_sram_burst_bridge_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    localparam int SW = DW / 8;

    // A beat transfers in any cycle where cyc & stb & (ack | err); the master holds
    // adr/dat/sel/we/cti/bte stable until that cycle, and the slave never stalls ack on ready.
    logic [AW-1:0] wb_adr_i;
    logic [DW-1:0] wb_dat_i;
    logic [SW-1:0] wb_sel_i;
    logic          wb_we_i;
    logic          wb_cyc_i;
    logic          wb_stb_i;
    logic [2:0]    wb_cti_i;
    logic [1:0]    wb_bte_i;
    logic          wb_ack_o;
    logic          wb_err_o;
    logic [DW-1:0] wb_dat_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        input  wb_ack_o, wb_err_o, wb_dat_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        output wb_ack_o, wb_err_o, wb_dat_o
    );
endinterface

// File: rtl/wb_sram_burst_bridge.sv
// Wishbone B3 slave turning classic and incrementing-burst cycles into accesses of a
// single-port SRAM with one cycle of registered read latency.
module wb_sram_burst_bridge #(
    parameter int AW            = 32,
    parameter int DW            = 32,
    parameter int WORD_AW       = AW - ((DW / 8) >> 1),
    parameter int MEM_SIZE_BYTE = 32768
) (
    input  logic                 clk,
    input  logic                 rst,
    wb_sram_burst_bridge_if.slave wb,
    output logic                 sram_ce,
    output logic                 sram_we,
    output logic [WORD_AW-1:0]   sram_waddr,
    output logic [DW-1:0]        sram_din,
    output logic [DW/8-1:0]      sram_sel,
    input  logic [DW-1:0]        sram_dout,
    output logic [1:0]           state_dbg
);
    localparam int SW = DW / 8;
    localparam int AS = SW >> 1;
    localparam logic [AW-1:0]      BYTE_LIMIT = AW'(MEM_SIZE_BYTE);
    localparam logic [WORD_AW-1:0] WORD_LIMIT = WORD_AW'(MEM_SIZE_BYTE / SW);

    if (!(DW == 8 || DW == 16 || DW == 32)) begin : g_bad_dw
        $error("wb_sram_burst_bridge: DW must be 8, 16 or 32");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SINGLE = 2'd1,
        BURST  = 2'd2,
        ERR    = 2'd3
    } state_t;

    state_t             state_q;
    logic [WORD_AW-1:0] beat_addr;
    logic [WORD_AW-1:0] next_addr;
    logic [WORD_AW-1:0] word_addr;
    logic               req;
    logic               hs;
    logic               ack;
    logic               err;
    logic               in_range;
    logic               next_in_range;
    logic               cti_incr;

    assign req           = wb.wb_cyc_i & wb.wb_stb_i;
    assign word_addr     = wb.wb_adr_i[AW-1:AS];
    assign in_range      = wb.wb_adr_i < BYTE_LIMIT;
    assign next_in_range = next_addr < WORD_LIMIT;
    assign cti_incr      = wb.wb_cti_i == 3'b010;
    assign hs            = ack & req;
    assign state_dbg     = state_q;

    // Wrap bursts only advance the low bits, so the beat stays inside its aligned block.
    always_comb begin
        next_addr = beat_addr + WORD_AW'(1);
        case (wb.wb_bte_i)
            2'b01:   next_addr = {beat_addr[WORD_AW-1:2], beat_addr[1:0] + 2'd1};
            2'b10:   next_addr = {beat_addr[WORD_AW-1:3], beat_addr[2:0] + 3'd1};
            2'b11:   next_addr = {beat_addr[WORD_AW-1:4], beat_addr[3:0] + 4'd1};
            default: next_addr = beat_addr + WORD_AW'(1);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            beat_addr <= '0;
        end else if (!wb.wb_cyc_i) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        beat_addr <= word_addr;
                        if (!in_range)     state_q <= ERR;
                        else if (cti_incr) state_q <= BURST;
                        else               state_q <= SINGLE;
                    end
                end
                SINGLE: state_q <= IDLE;
                BURST: begin
                    if (hs) begin
                        beat_addr <= next_addr;
                        // A last beat ends the burst before any range check on the next one.
                        if (!cti_incr)          state_q <= IDLE;
                        else if (!next_in_range) state_q <= ERR;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // IDLE always issues a speculative read so that read data is ready in the ack cycle;
    // burst reads pre-fetch the next beat on a handshake and re-read the held beat otherwise.
    always_comb begin
        ack        = 1'b0;
        err        = 1'b0;
        sram_we    = 1'b0;
        sram_ce    = 1'b0;
        sram_waddr = beat_addr;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    sram_waddr = word_addr;
                    sram_ce    = req;
                end
                SINGLE: begin
                    ack     = req;
                    sram_we = req & wb.wb_we_i;
                    sram_ce = req & wb.wb_we_i;
                end
                BURST: begin
                    ack = req;
                    if (wb.wb_we_i) begin
                        sram_we = req;
                        sram_ce = req;
                    end else begin
                        sram_waddr = req ? next_addr : beat_addr;
                        sram_ce    = wb.wb_cyc_i;
                    end
                end
                default: err = req;
            endcase
        end
    end

    assign sram_din    = wb.wb_dat_i;
    assign sram_sel    = wb.wb_sel_i;
    assign wb.wb_ack_o = ack;
    assign wb.wb_err_o = err;
    assign wb.wb_dat_o = ack ? sram_dout : '0;
endmodule

// File: tb/tb_wb_sram_burst_bridge.sv
// Directed bench for wb_sram_burst_bridge: behavioural SRAM, hand-computed expectations.
module tb_wb_sram_burst_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic        sram_ce;
    logic        sram_we;
    logic [29:0] sram_waddr;
    logic [31:0] sram_din;
    logic [3:0]  sram_sel;
    logic [31:0] sram_dout = 32'h0;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural SRAM: one-cycle registered read, byte-masked write.
    logic [31:0] mem [0:8191];
    int          wr_cnt = 0;
    logic [29:0] wr_addr_q [$];

    wb_sram_burst_bridge_if #(.AW(32), .DW(32)) wb ();

    wb_sram_burst_bridge #(
        .AW(32), .DW(32), .WORD_AW(30), .MEM_SIZE_BYTE(32768)
    ) dut (
        .clk(clk), .rst(rst), .wb(wb),
        .sram_ce(sram_ce), .sram_we(sram_we), .sram_waddr(sram_waddr),
        .sram_din(sram_din), .sram_sel(sram_sel), .sram_dout(sram_dout),
        .state_dbg(state_dbg)
    );

    // clock / reset block
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_ce && sram_we) begin
            wr_cnt <= wr_cnt + 1;
            wr_addr_q.push_back(sram_waddr);
            if (sram_waddr < 30'd8192)
                for (int b = 0; b < 4; b++)
                    if (sram_sel[b]) mem[sram_waddr[12:0]][8*b +: 8] <= sram_din[8*b +: 8];
        end else if (sram_ce) begin
            sram_dout <= (sram_waddr < 30'd8192) ? mem[sram_waddr[12:0]] : 32'h0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic mem_set(input logic [12:0] idx, input logic [31:0] val);
        mem[idx] <= val;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive(input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                         input logic [2:0] cti, input logic [1:0] bte);
        wb.wb_cyc_i = cyc;
        wb.wb_stb_i = stb;
        wb.wb_we_i  = we;
        wb.wb_adr_i = adr;
        wb.wb_dat_i = dat;
        wb.wb_sel_i = sel;
        wb.wb_cti_i = cti;
        wb.wb_bte_i = bte;
    endtask

    task automatic bus_idle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, 2'b00);
    endtask

    task automatic classic_read(input logic [31:0] adr, input logic [31:0] exp, input string tag);
        int wr0;
        wr0 = wr_cnt;
        tick(); drive(1'b1, 1'b1, 1'b0, adr, 32'h0, 4'hF, 3'b000, 2'b00);
        sample(); check({tag, "_ack_c0"}, 32'(wb.wb_ack_o), 32'd0);
        tick();
        sample(); check({tag, "_ack_c1"}, 32'(wb.wb_ack_o), 32'd1);
        check({tag, "_dat_c1"}, wb.wb_dat_o, exp);
        tick(); bus_idle();
        sample(); check({tag, "_ack_c2"}, 32'(wb.wb_ack_o), 32'd0);
        check({tag, "_no_write"}, 32'(wr_cnt), 32'(wr0));
    endtask

    logic [31:0] wrap_wa [4] = '{32'h42, 32'h43, 32'h40, 32'h41};
    int          wr_base;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 3'b000, 2'b00);
        mem_set(13'h4, 32'hCAFE_BABE);
        mem_set(13'h8, 32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) mem_set(13'h40 + 13'(i), 32'h5A00_0040 + 32'(i));
        mem_set(13'h1FFF, 32'h7FFC_0001);
        tick(); tick(); tick();
        sample();
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_ack", 32'(wb.wb_ack_o), 32'd0);
        check("rst_err", 32'(wb.wb_err_o), 32'd0);
        check("rst_ce", 32'(sram_ce), 32'd0);
        check("rst_we", 32'(sram_we), 32'd0);
        tick(); rst = 1'b0; bus_idle();
        sample(); check("post_rst_ack", 32'(wb.wb_ack_o), 32'd0);

        // classic read and byte-masked classic write with readback
        classic_read(32'h10, 32'hCAFE_BABE, "crd");
        wr_base = wr_cnt;
        tick(); drive(1'b1, 1'b1, 1'b1, 32'h20, 32'h1122_3344, 4'b0101, 3'b000, 2'b00);
        sample(); check("cwr_ack_c0", 32'(wb.wb_ack_o), 32'd0);
        tick();
        sample(); check("cwr_ack_c1", 32'(wb.wb_ack_o), 32'd1);
        check("cwr_we_c1", 32'(sram_we), 32'd1);
        check("cwr_addr_c1", {2'b0, sram_waddr}, 32'h8);
        tick(); bus_idle();
        sample(); check("cwr_ack_c2", 32'(wb.wb_ack_o), 32'd0);
        check("cwr_one_pulse", 32'(wr_cnt), 32'(wr_base + 1));
        classic_read(32'h20, 32'hFF22_FF44, "cwr_rb");

        // linear read burst of four
        tick(); drive(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 3'b010, 2'b00);
        sample(); check("lin_ack_c0", 32'(wb.wb_ack_o), 32'd0);
        for (int b = 0; b < 4; b++) begin
            tick();
            drive(1'b1, 1'b1, 1'b0, 32'h100 + 32'(4 * b), 32'h0, 4'hF,
                  (b == 3) ? 3'b111 : 3'b010, 2'b00);
            sample();
            check($sformatf("lin_ack_b%0d", b), 32'(wb.wb_ack_o), 32'd1);
            check($sformatf("lin_dat_b%0d", b), wb.wb_dat_o, 32'h5A00_0040 + 32'(b));
        end
        tick(); bus_idle();
        sample(); check("lin_ack_end", 32'(wb.wb_ack_o), 32'd0);
        check("lin_state_end", 32'(state_dbg), 32'd0);

        // wrap4 write burst from 0x108 with a master wait state after beat 1
        wr_addr_q.delete();
        tick(); drive(1'b1, 1'b1, 1'b1, 32'h108, 32'hD000_0000, 4'hF, 3'b010, 2'b01);
        sample(); check("wrap_ack_c0", 32'(wb.wb_ack_o), 32'd0);
        for (int b = 0; b < 4; b++) begin
            if (b == 2) begin
                tick(); drive(1'b1, 1'b0, 1'b1, 32'h100, 32'hD000_0002, 4'hF, 3'b010, 2'b01);
                sample();
                check("wrap_wait_ack", 32'(wb.wb_ack_o), 32'd0);
                check("wrap_wait_we", 32'(sram_we), 32'd0);
            end
            tick();
            drive(1'b1, 1'b1, 1'b1, wrap_wa[b] << 2, 32'hD000_0000 + 32'(b), 4'hF,
                  (b == 3) ? 3'b111 : 3'b010, 2'b01);
            sample(); check($sformatf("wrap_ack_b%0d", b), 32'(wb.wb_ack_o), 32'd1);
        end
        tick(); bus_idle();
        sample(); check("wrap_state_end", 32'(state_dbg), 32'd0);
        check("wrap_nwrites", 32'(wr_addr_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wrap_order_%0d", i),
                  (i < wr_addr_q.size()) ? {2'b0, wr_addr_q[i]} : 32'hFFFF_FFFF, wrap_wa[i]);
            check($sformatf("wrap_mem_%0d", i), mem[13'(wrap_wa[i])], 32'hD000_0000 + 32'(i));
        end

        // out-of-range classic write: single err, no ack, no SRAM write
        wr_base = wr_cnt;
        tick(); drive(1'b1, 1'b1, 1'b1, 32'h8000, 32'hDEAD_BEEF, 4'hF, 3'b000, 2'b00);
        sample(); check("oor_err_c0", 32'(wb.wb_err_o), 32'd0);
        tick();
        sample(); check("oor_err_c1", 32'(wb.wb_err_o), 32'd1);
        check("oor_ack_c1", 32'(wb.wb_ack_o), 32'd0);
        tick(); bus_idle();
        sample(); check("oor_err_c2", 32'(wb.wb_err_o), 32'd0);
        check("oor_no_write", 32'(wr_cnt), 32'(wr_base));

        // burst running off the end of memory
        tick(); drive(1'b1, 1'b1, 1'b0, 32'h7FFC, 32'h0, 4'hF, 3'b010, 2'b00);
        sample(); check("edge_ack_c0", 32'(wb.wb_ack_o), 32'd0);
        tick();
        sample(); check("edge_ack_b0", 32'(wb.wb_ack_o), 32'd1);
        check("edge_dat_b0", wb.wb_dat_o, 32'h7FFC_0001);
        check("edge_err_b0", 32'(wb.wb_err_o), 32'd0);
        tick(); drive(1'b1, 1'b1, 1'b0, 32'h8000, 32'h0, 4'hF, 3'b111, 2'b00);
        sample(); check("edge_ack_b1", 32'(wb.wb_ack_o), 32'd0);
        check("edge_err_b1", 32'(wb.wb_err_o), 32'd1);
        tick(); bus_idle();
        sample(); check("edge_err_end", 32'(wb.wb_err_o), 32'd0);
        check("edge_state_end", 32'(state_dbg), 32'd0);

        // reset asserted mid-burst
        tick(); drive(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 3'b010, 2'b00);
        tick();
        sample(); check("rmid_ack_b0", 32'(wb.wb_ack_o), 32'd1);
        tick(); drive(1'b1, 1'b1, 1'b0, 32'h104, 32'h0, 4'hF, 3'b010, 2'b00);
        tick(); drive(1'b1, 1'b1, 1'b0, 32'h108, 32'h0, 4'hF, 3'b010, 2'b00); rst = 1'b1;
        sample(); check("rmid_ack_rst", 32'(wb.wb_ack_o), 32'd0);
        check("rmid_ce_rst", 32'(sram_ce), 32'd0);
        tick(); rst = 1'b0;
        sample(); check("rmid_ack_after", 32'(wb.wb_ack_o), 32'd0);
        check("rmid_state_after", 32'(state_dbg), 32'd0);
        tick(); bus_idle();
        classic_read(32'h10, 32'hCAFE_BABE, "rmid_crd");

        // cyc dropped mid-burst
        tick(); drive(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 3'b010, 2'b00);
        tick();
        sample(); check("cdrop_ack_b0", 32'(wb.wb_ack_o), 32'd1);
        tick(); drive(1'b0, 1'b1, 1'b0, 32'h104, 32'h0, 4'hF, 3'b010, 2'b00);
        sample(); check("cdrop_ack", 32'(wb.wb_ack_o), 32'd0);
        tick(); bus_idle();
        sample(); check("cdrop_state", 32'(state_dbg), 32'd0);
        classic_read(32'h20, 32'hFF22_FF44, "cdrop_crd");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/wb_sram_burst_bridge.md
Name: wb_sram_burst_bridge

Overview:
- Wishbone B3 slave that converts bus cycles into single-port SRAM accesses. It drives the SRAM's ce/we/waddr/din/sel and consumes its dout, which has 1-cycle registered read latency.
- Sits between the tile bus or NoC DMA master and the local SRAM.
- Supports classic single cycles and incrementing bursts (linear, wrap-4/8/16), sustaining one beat per cycle in bursts.
- Flags out-of-range addresses with wb_err_o.

Parameters:
- AW, 32: Wishbone byte address width.
- DW, 32: data width; must be 8, 16 or 32. SW = DW/8 is derived.
- WORD_AW, AW-(SW>>1): SRAM word address width.
- MEM_SIZE_BYTE, 32768: memory size in bytes; accesses at or above this size get an error response.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- wb_adr_i  in  AW  byte address.
- wb_dat_i  in  DW  write data.
- wb_sel_i  in  SW  byte selects.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  cycle valid.
- wb_stb_i  in  1  strobe.
- wb_cti_i  in  3  cycle type: 000 classic, 010 incrementing, 111 end-of-burst.
- wb_bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- wb_ack_o  out  1  beat acknowledge.
- wb_err_o  out  1  error acknowledge.
- wb_dat_o  out  DW  read data.
- sram_ce  out  1  SRAM chip enable.
- sram_we  out  1  SRAM write enable.
- sram_waddr  out  WORD_AW  SRAM word address.
- sram_din  out  DW  SRAM write data.
- sram_sel  out  SW  SRAM byte selects.
- sram_dout  in  DW  SRAM read data, valid 1 cycle after the address.

Behaviour:
- Clocking and reset:
  - Single clock clk. Reset rst is synchronous, active-high.
  - Under reset: state is IDLE, beat_addr is 0, err_q is 0.
  - Outputs under reset: wb_ack_o=0, wb_err_o=0, sram_we=0, sram_ce=0.
- State machine: IDLE, SINGLE, BURST, ERR.
- Access decode:
  - req = wb_cyc_i & wb_stb_i.
  - hs = wb_ack_o & req (beat handshake).
  - Word address = wb_adr_i[AW-1:SW>>1].
- IDLE:
  - wb_ack_o=0.
  - sram_waddr = word address of wb_adr_i; sram_ce=req; sram_we=0. This is a speculative read.
  - On req with wb_adr_i >= MEM_SIZE_BYTE: go to ERR.
  - Else on req with cti=010: go to BURST and latch beat_addr.
  - Else on req: go to SINGLE and latch beat_addr.
- SINGLE:
  - wb_ack_o = req.
  - Read: wb_dat_o = sram_dout (data of the address presented in IDLE).
  - Write: sram_we = req & wb_we_i; sram_waddr = beat_addr; sram_din = wb_dat_i; sram_sel = wb_sel_i.
  - Next state is IDLE unconditionally, so a classic access takes 2 cycles.
  - A request still asserted in the cycle after the ack is treated as a new access.
- BURST:
  - wb_ack_o = req. A master wait state (stb low) gives no ack and holds beat_addr.
  - Write beats: write to beat_addr in the ack cycle.
  - Read beats: sram_waddr = hs ? next_addr : beat_addr. This keeps dout valid for the following beat, or for the held beat during a wait.
  - On hs: beat_addr <= next_addr.
  - If hs & cti=111, or hs & cti not 010: go to IDLE after this beat.
  - If next_addr crosses MEM_SIZE_BYTE: that next beat gets err instead of ack, then go to IDLE.
- ERR: wb_err_o=1 for exactly one cycle if req; wb_ack_o=0; no SRAM write; then IDLE.
- next_addr:
  - Linear: beat_addr+1, modulo 2^WORD_AW.
  - wrap4/8/16: increment the low 2/3/4 bits only; upper bits unchanged.
- Exclusivity: wb_ack_o and wb_err_o are never asserted together.
- wb_cyc_i deasserted in any state: go to IDLE next cycle, no ack, no SRAM write.
- sram_ce = 1 whenever sram_we or a read address is presented; otherwise 0.
- wb_dat_o is 0 when wb_ack_o is 0.

Test Plan:
- Classic read at 0x10, mem[4]=0xCAFEBABE: stb cycle 0 -> ack cycle 1 with dat=0xCAFEBABE, ack=0 cycle 2, sram_we never 1.
- Classic write 0x20, data 0x11223344, sel=0101 over old 0xFFFFFFFF -> ack cycle 1, single sram_we pulse, readback 0xFF22FF44.
- Linear read burst of 4 from 0x100 (cti 010,010,010,111) -> acks on 4 consecutive cycles starting cycle 1, data mem[0x40..0x43], IDLE after.
- Wrap4 write burst from 0x108 -> words written in order 0x42,0x43,0x40,0x41; a stb-low wait mid-burst inserts no ack and no write.
- Access to MEM_SIZE_BYTE (0x8000) -> err=1 for one cycle, ack=0, memory unchanged; a burst from 0x7FFC gets ack on the first beat, err on the second.
- rst asserted mid-burst, and separately cyc dropped mid-burst -> ack=0 next cycle, state IDLE; the following classic read completes normally in 2 cycles.
